// File: rtl/bridge_req_queue.sv
// bridge_req_queue: in-order request FIFO feeding one DRAM-bridge transaction at a time,
// with in-order completion strobes and a sticky stuck-bridge watchdog.
module bridge_req_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_r_wb,
  input  logic [7:0]  req_addr,
  input  logic [63:0] req_data,
  output logic        rsp_valid,
  output logic        rsp_r_wb,
  output logic [7:0]  rsp_addr,
  output logic [63:0] rsp_data,
  output logic        C_in_valid,
  output logic        C_r_wb,
  output logic [7:0]  C_addr,
  output logic [63:0] C_data_w,
  input  logic        C_out_valid,
  input  logic [63:0] C_data_r,
  output logic        busy,
  output logic        err_timeout
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RSP} state_t;
  state_t state, state_nx;
  logic [72:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [9:0] wd;
  logic push, pop;
  // count never exceeds DEPTH (a power of 2), so its MSB alone means full
  assign req_ready = ~count[AW];
  assign push = req_valid & req_ready;
  assign pop = (count != '0) && (state == IDLE || state == RSP);
  assign C_in_valid = state == ISSUE;
  assign rsp_valid = state == RSP;
  assign busy = (count != '0) || (state != IDLE);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (count != '0) ? ISSUE : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = C_out_valid ? RSP : WAIT;
      RSP:     state_nx = (count != '0) ? ISSUE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {req_r_wb, req_addr, req_data};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      wd          <= '0;
      err_timeout <= 1'b0;
      C_r_wb      <= 1'b0;
      C_addr      <= '0;
      C_data_w    <= '0;
      rsp_r_wb    <= 1'b0;
      rsp_addr    <= '0;
      rsp_data    <= '0;
    end else begin
      state <= state_nx;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        {C_r_wb, C_addr, C_data_w} <= mem[rd_ptr];
      end
      // watchdog counts WAIT cycles and saturates so it cannot wrap back under TIMEOUT
      if (state == ISSUE) wd <= '0;
      else if (state == WAIT && wd != 10'(TIMEOUT)) wd <= wd + 1'b1;
      if (state == WAIT && wd == 10'(TIMEOUT - 1)) err_timeout <= 1'b1;
      if (state == WAIT && C_out_valid) begin
        rsp_r_wb <= C_r_wb;
        rsp_addr <= C_addr;
        rsp_data <= C_r_wb ? C_data_r : '0;
      end
    end
  end
endmodule

// File: tb/tb_bridge_req_queue.sv
// tb_bridge_req_queue: directed, cycle-exact checks of queueing, sequencing, watchdog and reset.
module tb_bridge_req_queue;
  localparam int TIMEOUT = 1023;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_r_wb = 1'b0, C_out_valid = 1'b0;
  logic [7:0] req_addr = '0;
  logic [63:0] req_data = '0, C_data_r = '0;
  logic req_ready, rsp_valid, rsp_r_wb, C_in_valid, C_r_wb, busy, err_timeout;
  logic [7:0] rsp_addr, C_addr;
  logic [63:0] rsp_data, C_data_w;
  int nchk = 0, nfail = 0;
  logic [63:0] stored;

  bridge_req_queue #(.DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_r_wb(req_r_wb), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_r_wb(rsp_r_wb), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr), .C_data_w(C_data_w),
    .C_out_valid(C_out_valid), .C_data_r(C_data_r), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 200us");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    nchk++; if (req_ready !== 1'b1) begin nfail++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    nchk++; if ({rsp_valid, C_in_valid, busy, err_timeout} !== 4'b0) begin nfail++; $display("FAIL rst_flags: got %b want 0000", {rsp_valid, C_in_valid, busy, err_timeout}); end
    nchk++; if ({C_r_wb, C_addr, C_data_w, rsp_r_wb, rsp_addr, rsp_data} !== '0) begin nfail++; $display("FAIL rst_regs: got nonzero C_addr=%h rsp_addr=%h", C_addr, rsp_addr); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write;
    req_valid = 1'b1; req_r_wb = 1'b0; req_addr = 8'h05; req_data = 64'hDEAD_BEEF_0000_0001;
    tick();
    req_valid = 1'b0;
    nchk++; if (C_in_valid !== 1'b0) begin nfail++; $display("FAIL t1_civ_early: got %b want 0", C_in_valid); end
    tick();
    nchk++; if (C_in_valid !== 1'b1) begin nfail++; $display("FAIL t1_civ: got %b want 1", C_in_valid); end
    nchk++; if ({C_r_wb, C_addr} !== {1'b0, 8'h05}) begin nfail++; $display("FAIL t1_c_req: got %b/%h want 0/05", C_r_wb, C_addr); end
    nchk++; if (C_data_w !== 64'hDEAD_BEEF_0000_0001) begin nfail++; $display("FAIL t1_c_data: got %h want deadbeef00000001", C_data_w); end
    stored = C_data_w;
    tick();
    nchk++; if (C_in_valid !== 1'b0) begin nfail++; $display("FAIL t1_civ_pulse: got %b want 0", C_in_valid); end
    tick(); tick();
    C_out_valid = 1'b1;
    nchk++; if (rsp_valid !== 1'b0) begin nfail++; $display("FAIL t1_rsp_early: got %b want 0", rsp_valid); end
    tick();
    C_out_valid = 1'b0;
    nchk++; if (rsp_valid !== 1'b1) begin nfail++; $display("FAIL t1_rsp: got %b want 1", rsp_valid); end
    nchk++; if ({rsp_r_wb, rsp_addr, rsp_data} !== {1'b0, 8'h05, 64'h0}) begin nfail++; $display("FAIL t1_rsp_fields: got %b/%h/%h want 0/05/0", rsp_r_wb, rsp_addr, rsp_data); end
    tick();
    nchk++; if ({rsp_valid, busy} !== 2'b00) begin nfail++; $display("FAIL t1_idle: got %b want 00", {rsp_valid, busy}); end
  endtask

  task automatic test_write_read;
    req_valid = 1'b1; req_r_wb = 1'b0; req_addr = 8'h05; req_data = 64'hDEAD_BEEF_0000_0001;
    tick();
    req_r_wb = 1'b1; req_data = 64'h0;
    tick();
    req_valid = 1'b0;
    nchk++; if ({C_in_valid, C_r_wb} !== 2'b10) begin nfail++; $display("FAIL t2_issue_w: got %b want 10", {C_in_valid, C_r_wb}); end
    stored = C_data_w;
    tick();
    C_out_valid = 1'b1;
    tick();
    C_out_valid = 1'b0;
    nchk++; if ({rsp_valid, rsp_r_wb, rsp_data} !== {2'b10, 64'h0}) begin nfail++; $display("FAIL t2_rsp_w: got %b%b/%h want 10/0", rsp_valid, rsp_r_wb, rsp_data); end
    tick();
    nchk++; if ({C_in_valid, C_r_wb, C_addr} !== {2'b11, 8'h05}) begin nfail++; $display("FAIL t2_issue_r: got %b%b/%h want 11/05", C_in_valid, C_r_wb, C_addr); end
    tick();
    C_out_valid = 1'b1; C_data_r = stored;
    tick();
    C_out_valid = 1'b0; C_data_r = 64'h0;
    nchk++; if ({rsp_valid, rsp_r_wb, rsp_addr} !== {2'b11, 8'h05}) begin nfail++; $display("FAIL t2_rsp_r: got %b%b/%h want 11/05", rsp_valid, rsp_r_wb, rsp_addr); end
    nchk++; if (rsp_data !== 64'hDEAD_BEEF_0000_0001) begin nfail++; $display("FAIL t2_rsp_data: got %h want deadbeef00000001", rsp_data); end
    tick();
    C_out_valid = 1'b1; C_data_r = 64'h1234;
    tick();
    C_out_valid = 1'b0; C_data_r = 64'h0;
    nchk++; if ({rsp_valid, busy} !== 2'b00) begin nfail++; $display("FAIL t2_stray_ack: got %b want 00", {rsp_valid, busy}); end
    nchk++; if (rsp_data !== 64'hDEAD_BEEF_0000_0001) begin nfail++; $display("FAIL t2_rsp_hold: got %h want deadbeef00000001", rsp_data); end
  endtask

  task automatic test_full;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_r_wb = i[0]; req_addr = 8'h10 + 8'(i); req_data = {8{8'h10 + 8'(i)}};
      nchk++; if (req_ready !== (i < 5)) begin nfail++; $display("FAIL t3_ready_%0d: got %b want %b", i, req_ready, i < 5); end
      if (i == 2) begin
        nchk++; if ({C_in_valid, C_addr} !== {1'b1, 8'h10}) begin nfail++; $display("FAIL t3_issue0: got %b/%h want 1/10", C_in_valid, C_addr); end
      end
      tick();
    end
    nchk++; if ({req_ready, busy, C_in_valid, rsp_valid} !== 4'b0100) begin nfail++; $display("FAIL t3_stalled: got %b want 0100", {req_ready, busy, C_in_valid, rsp_valid}); end
    C_out_valid = 1'b1; C_data_r = 64'hCAFE_0000_0000_0010;
    tick();
    C_out_valid = 1'b0;
    nchk++; if ({rsp_valid, rsp_addr, req_ready} !== {1'b1, 8'h10, 1'b0}) begin nfail++; $display("FAIL t3_rsp0: got %b/%h/%b want 1/10/0", rsp_valid, rsp_addr, req_ready); end
    tick();
    nchk++; if ({req_ready, C_in_valid, C_addr} !== {2'b11, 8'h11}) begin nfail++; $display("FAIL t3_reopen: got %b%b/%h want 11/11", req_ready, C_in_valid, C_addr); end
    tick();
    req_valid = 1'b0;
    nchk++; if (req_ready !== 1'b0) begin nfail++; $display("FAIL t3_refull: got %b want 0", req_ready); end
    C_out_valid = 1'b1; C_data_r = 64'hCAFE_0000_0000_0011;
    tick();
    C_out_valid = 1'b0;
    nchk++; if ({rsp_valid, rsp_r_wb, rsp_addr, rsp_data} !== {2'b11, 8'h11, 64'hCAFE_0000_0000_0011}) begin nfail++; $display("FAIL t3_rsp1: got %b%b/%h/%h want 11/11/cafe000000000011", rsp_valid, rsp_r_wb, rsp_addr, rsp_data); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [7:0] a;
    logic rw;
    for (int k = 2; k < 6; k++) begin
      a = 8'h10 + 8'(k); rw = k[0];
      nchk++; if ({C_in_valid, C_r_wb, C_addr} !== {1'b1, rw, a}) begin nfail++; $display("FAIL t4_issue_%0d: got %b%b/%h want 1%b/%h", k, C_in_valid, C_r_wb, C_addr, rw, a); end
      nchk++; if (C_data_w !== {8{a}}) begin nfail++; $display("FAIL t4_wdata_%0d: got %h want %h", k, C_data_w, {8{a}}); end
      tick();
      nchk++; if (C_in_valid !== 1'b0) begin nfail++; $display("FAIL t4_gap_%0d: got %b want 0", k, C_in_valid); end
      C_out_valid = 1'b1; C_data_r = {56'hCAFE_0000_0000_00, a};
      tick();
      C_out_valid = 1'b0;
      nchk++; if ({rsp_valid, rsp_r_wb, rsp_addr} !== {1'b1, rw, a}) begin nfail++; $display("FAIL t4_rsp_%0d: got %b%b/%h want 1%b/%h", k, rsp_valid, rsp_r_wb, rsp_addr, rw, a); end
      nchk++; if (rsp_data !== (rw ? {56'hCAFE_0000_0000_00, a} : 64'h0)) begin nfail++; $display("FAIL t4_rdata_%0d: got %h", k, rsp_data); end
      tick();
    end
    nchk++; if ({C_in_valid, rsp_valid, busy} !== 3'b000) begin nfail++; $display("FAIL t4_drained: got %b want 000", {C_in_valid, rsp_valid, busy}); end
    nchk++; if (rsp_addr !== 8'h15) begin nfail++; $display("FAIL t4_hold: got %h want 15", rsp_addr); end
  endtask

  task automatic test_timeout;
    req_valid = 1'b1; req_r_wb = 1'b1; req_addr = 8'h33; req_data = 64'h0;
    tick();
    req_valid = 1'b0;
    tick();
    nchk++; if ({C_in_valid, err_timeout} !== 2'b10) begin nfail++; $display("FAIL t5_issue: got %b want 10", {C_in_valid, err_timeout}); end
    for (int i = 0; i < TIMEOUT; i++) tick();
    nchk++; if (err_timeout !== 1'b0) begin nfail++; $display("FAIL t5_early: got %b want 0", err_timeout); end
    tick();
    nchk++; if (err_timeout !== 1'b1) begin nfail++; $display("FAIL t5_rise: got %b want 1", err_timeout); end
    for (int i = 0; i < 20; i++) tick();
    nchk++; if ({err_timeout, busy, rsp_valid, C_in_valid} !== 4'b1100) begin nfail++; $display("FAIL t5_sticky: got %b want 1100", {err_timeout, busy, rsp_valid, C_in_valid}); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_r_wb = 1'b0; req_addr = 8'h40 + 8'(i); req_data = 64'(i);
      tick();
    end
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    nchk++; if ({rsp_valid, C_in_valid, busy, err_timeout, req_ready} !== 5'b00001) begin nfail++; $display("FAIL t6_async: got %b want 00001", {rsp_valid, C_in_valid, busy, err_timeout, req_ready}); end
    nchk++; if ({C_r_wb, C_addr, C_data_w, rsp_r_wb, rsp_addr, rsp_data} !== '0) begin nfail++; $display("FAIL t6_regs: got C_addr=%h rsp_addr=%h want 0", C_addr, rsp_addr); end
    tick();
    rst_n = 1'b1; C_out_valid = 1'b1; C_data_r = 64'hFFFF;
    tick();
    C_out_valid = 1'b0;
    nchk++; if ({rsp_valid, busy, err_timeout, C_in_valid} !== 4'b0000) begin nfail++; $display("FAIL t6_late_ack: got %b want 0000", {rsp_valid, busy, err_timeout, C_in_valid}); end
    tick(); tick();
    nchk++; if ({rsp_valid, C_in_valid, busy} !== 3'b000) begin nfail++; $display("FAIL t6_quiet: got %b want 000", {rsp_valid, C_in_valid, busy}); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_write_read();
    test_full();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
